// File: rtl/ervp_printf_uart_capture.sv
// ervp_printf_uart_capture: 8N1 UART receiver for the printf_tx pin feeding a fall-through byte FIFO
module ervp_printf_uart_capture #(
    parameter int DIVISOR    = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstpp,
    input  logic                          rx,
    input  logic                          clear,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [7:0]                    byte_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_error
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] FULL_T = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_T = CW'(DIVISOR / 2 - 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta, rx_sync, rx_prev;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          fall, tick, stop_tick, push, pop, full, wr_en;

    assign fall       = rx_prev & ~rx_sync;
    assign tick       = cnt == ((state == START) ? HALF_T : FULL_T);
    assign stop_tick  = state == STOP && tick;
    assign push       = stop_tick && rx_sync;
    assign byte_valid = fifo_count != '0;
    assign pop        = byte_valid && byte_ready;
    assign full       = fifo_count == (AW + 1)'(FIFO_DEPTH);
    // a full FIFO still accepts a byte when the head leaves on the same edge
    assign wr_en      = push && (!full || pop);
    assign byte_data  = byte_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: if (tick) state <= rx_sync ? IDLE : DATA;
                DATA: begin
                    if (tick) begin
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                default: if (tick) state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge rstpp) begin
        if (rstpp) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            overflow    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            if (push && full && !pop) overflow <= 1'b1;
            if (stop_tick && !rx_sync) frame_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ervp_printf_uart_capture.sv
// tb_ervp_printf_uart_capture: random and directed UART frames checked by a queue scoreboard
module tb_ervp_printf_uart_capture;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;
    // 2 sync flops + edge detect, half a bit to mid-start, then 9 bit times to mid-stop
    localparam int PUSH_EDGE = 3 + DIV / 2 + 9 * DIV;

    logic       clk, rstpp, rx, clear, byte_ready;
    logic       byte_valid, overflow, frame_error;
    logic [7:0] byte_data;
    logic [2:0] fifo_count;

    logic [7:0] exp_q[$];
    logic       exp_ovf, exp_ferr;
    bit         rnd_ready;
    int         n_chk, n_pass;

    ervp_printf_uart_capture #(.DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstpp(rstpp), .rx(rx), .clear(clear),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .fifo_count(fifo_count), .overflow(overflow), .frame_error(frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) byte_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int pop_at);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        if (!stop) exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH || pop_at >= 0) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        for (int k = 0; k < 10 * DIV; k++) begin
            rx = f[k / DIV];
            if (pop_at >= 0) byte_ready = (k == pop_at);
            tick();
        end
        rx = 1'b1;
        if (pop_at >= 0) byte_ready = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drain();
        byte_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && byte_valid; i++) tick();
        byte_ready = 1'b0;
        chk("drain_valid", byte_valid, 0);
        chk("drain_scoreboard", exp_q.size(), 0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_valid"}, byte_valid, exp_q.size() != 0);
        chk({tag, "_count"}, fifo_count, exp_q.size());
        chk({tag, "_overflow"}, overflow, exp_ovf);
        chk({tag, "_frame_error"}, frame_error, exp_ferr);
        if (exp_q.size() != 0) chk({tag, "_data"}, byte_data, exp_q[0]);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
        check_state("clear");
    endtask

    always @(negedge clk) begin
        if (!rstpp && !clear && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL pop_unexpected: got 0x%0h, want no byte", byte_data);
            end else chk("pop_data", byte_data, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b3c;
        n_chk = 0; n_pass = 0;
        rx = 1'b1; clear = 1'b0; byte_ready = 1'b0; rnd_ready = 1'b0;
        exp_ovf = 1'b0; exp_ferr = 1'b0;
        rstpp = 1'b0;
        #2 rstpp = 1'b1;
        repeat (3) tick();
        chk("reset_valid", byte_valid, 0);
        chk("reset_data", byte_data, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_frame_error", frame_error, 0);
        rstpp = 1'b0;
        repeat (3) tick();

        send(8'h55, 1'b1, -1);
        check_state("single_55");
        drain();

        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (4 * DIV) tick();
        check_state("glitch");

        send(8'hA3, 1'b0, -1);
        check_state("bad_stop");
        send(8'h12, 1'b1, -1);
        check_state("after_bad_stop");
        drain();
        do_clear();

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1);
        check_state("fill_overflow");
        drain();
        chk("overflow_sticky", overflow, exp_ovf);
        do_clear();

        for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 1'b1, -1);
        check_state("full");
        send(8'h14, 1'b1, PUSH_EDGE - 1);
        check_state("full_push_pop");
        drain();
        do_clear();

        b3c = 8'h3C;
        rx = 1'b0;
        repeat (DIV) tick();
        for (int i = 0; i < 3; i++) begin
            rx = b3c[i];
            repeat (DIV) tick();
        end
        rstpp = 1'b1;
        rx = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_ferr = 1'b0;
        repeat (2) tick();
        rstpp = 1'b0;
        repeat (12 * DIV) tick();
        check_state("reset_midframe");
        send(8'h7E, 1'b1, -1);
        check_state("after_reset");
        do_clear();

        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 1'($urandom_range(0, 7) != 0), -1);
            repeat ($urandom_range(0, 5)) tick();
        end
        rnd_ready = 1'b0;
        byte_ready = 1'b0;
        drain();
        chk("random_frame_error", frame_error, exp_ferr);
        chk("random_overflow", overflow, exp_ovf);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ervp_printf_uart_capture.md
ERVP_PRINTF_UART_CAPTURE -- requirements
Module: ervp_printf_uart_capture

Interface
REQ-001 Parameter DIVISOR, default 16: clk cycles per UART bit; legal values >= 4.
REQ-002 Parameter FIFO_DEPTH, default 16: byte FIFO entries; power of two, >= 2.
REQ-003 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 Port rstpp, input, 1: asynchronous, active-high reset.
REQ-005 Port rx, input, 1: asynchronous serial line, 8N1, idle high; driven from the platform printf_tx pin.
REQ-006 Port clear, input, 1: synchronous flush of the FIFO, flags and receiver.
REQ-007 Port byte_valid, output, 1: FIFO non-empty.
REQ-008 Port byte_ready, input, 1: consumer accepts the head byte.
REQ-009 Port byte_data, output, 8: FIFO head byte, first-word fall-through.
REQ-010 Port fifo_count, output, log2(FIFO_DEPTH)+1: number of occupied entries.
REQ-011 Port overflow, output, 1: sticky; a received byte was dropped because the FIFO was full.
REQ-012 Port frame_error, output, 1: sticky; a stop bit was sampled low.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all further references to rx mean the synchronized value.
REQ-014 The receiver FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 IDLE -> START on a 1-to-0 transition of rx; the bit counter loads 0.
REQ-016 START: after DIVISOR/2 (floor) cycles, sample rx; if 0 -> DATA, if 1 -> IDLE (glitch, nothing recorded).
REQ-017 DATA: sample every DIVISOR cycles; 8 samples, LSB first, shifted into the shift register; after the 8th sample -> STOP.
REQ-018 STOP: sample after DIVISOR cycles, then -> IDLE; sample 1 -> push byte; sample 0 -> set frame_error, discard byte.
REQ-019 A pushed byte SHALL appear on byte_data/byte_valid on the cycle after the stop-bit sample.
REQ-020 Pop occurs when byte_valid && byte_ready; byte_data and fifo_count update on the next cycle.
REQ-021 Push while full without pop: byte dropped, overflow set, FIFO contents unchanged.
REQ-022 Push and pop in the same cycle SHALL both occur, including when full; fifo_count unchanged.
REQ-023 byte_ready while empty SHALL be ignored.
REQ-024 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count range 0..FIFO_DEPTH.
REQ-025 clear SHALL zero the pointers, fifo_count, overflow and frame_error and force IDLE next cycle; it overrides a simultaneous push or pop.
REQ-026 overflow and frame_error SHALL remain set until clear or rstpp.

Reset
REQ-027 rstpp SHALL force IDLE, counters 0, FIFO empty, byte_valid=0, byte_data=0, fifo_count=0, overflow=0, frame_error=0, and synchronizer flops to 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; no partial byte is pushed after release.

Verification
REQ-029 DIVISOR=8: send 0x55 with byte_ready=0 -> byte_valid=1, byte_data=0x55, fifo_count=1, no flags.
REQ-030 Low pulse of 2 cycles on rx -> FSM returns to IDLE; fifo_count stays 0; no flags.
REQ-031 Frame 0xA3 with stop bit low -> frame_error=1, fifo_count=0; following good frame 0x12 -> byte_data=0x12, frame_error still 1.
REQ-032 FIFO_DEPTH=4, byte_ready=0, send 0x01..0x05 -> fifo_count=4, overflow=1; pops return 0x01,0x02,0x03,0x04.
REQ-033 FIFO full; byte_ready=1 on the push cycle of a 5th byte -> fifo_count stays 4, overflow=0, the new byte becomes the last entry.
REQ-034 rstpp pulse during DATA of byte 0x3C, then full frame 0x7E -> only 0x7E received, fifo_count=1; clear then gives fifo_count=0, flags 0.
